// File: rtl/arb_pack_pkg.sv
// rtl/arb_pack_pkg.sv - shared constants and helpers for the arbiter word packer
package arb_pack_pkg;

    localparam int BYTE_W     = 8;
    localparam int WORD_BYTES = 4;
    localparam int LANE_W     = 2;
    localparam int WORD_W     = 32;
    localparam int ENTRY_W    = WORD_BYTES + WORD_W;

    // Accumulator control states: EMPTY holds no bytes, PARTIAL holds 1-3
    localparam logic [0:0] ST_EMPTY   = 1'b0;
    localparam logic [0:0] ST_PARTIAL = 1'b1;

    // Contiguous lane-enable mask for a word holding n bytes (n = 0..4)
    function automatic logic [WORD_BYTES-1:0] be_mask(input logic [LANE_W:0] n);
        logic [WORD_BYTES-1:0] m;
        case (n)
            3'd1:    m = 4'b0001;
            3'd2:    m = 4'b0011;
            3'd3:    m = 4'b0111;
            3'd4:    m = 4'b1111;
            default: m = 4'b0000;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/arb_word_packer_word_queue.sv
// rtl/arb_word_packer_word_queue.sv - small synchronous FIFO holding completed words
module word_queue #(
    parameter int WIDTH = 36,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             wr_en;
    logic             rd_en;

    assign full  = (count == DEPTH_C);
    assign empty = (count == '0);
    assign head  = mem[rd_ptr];

    // A pop in the same cycle frees the slot a full-queue push needs
    assign wr_en = push && (!full || pop);
    assign rd_en = pop && !empty;

    // Storage, pointers (wrap naturally at power-of-two depth) and occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (wr_en) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_en, rd_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/arb_word_packer.sv
// rtl/arb_word_packer.sv - packs the arbiter byte stream into 32-bit words with byte enables
module arb_word_packer
    import arb_pack_pkg::*;
#(
    parameter int OUT_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [BYTE_W-1:0]     din,
    input  logic                  din_valid,
    input  logic                  flush,
    output logic [WORD_W-1:0]     word_out,
    output logic [WORD_BYTES-1:0] be_out,
    output logic                  word_valid,
    input  logic                  word_ready,
    output logic                  overflow,
    output logic                  overflow_sticky,
    output logic [LANE_W-1:0]     fill
);

    logic [0:0]            state;
    logic [LANE_W-1:0]     lane;
    logic [WORD_W-1:0]     acc;
    logic [WORD_W-1:0]     acc_wr;
    logic [LANE_W:0]       bytes_after;
    logic                  complete;
    logic                  pop;
    logic                  drop;
    logic                  q_full;
    logic                  q_empty;
    logic [ENTRY_W-1:0]    q_head;

    // Word as it would look with this cycle's byte merged into its lane
    always_comb begin
        acc_wr = acc;
        if (din_valid) begin
            acc_wr[{lane, 3'b000} +: BYTE_W] = din;
        end
    end

    assign bytes_after = {1'b0, lane} + {{LANE_W{1'b0}}, din_valid};

    // Full word on the fourth byte, or a flush while any byte is held or arriving
    assign complete = (din_valid && (lane == 2'd3))
                   || (flush && ((state == ST_PARTIAL) || din_valid));

    assign pop  = word_valid && word_ready;
    assign drop = complete && q_full && !pop;

    word_queue #(
        .WIDTH (ENTRY_W),
        .DEPTH (OUT_DEPTH)
    ) u_queue (
        .clk       (clk),
        .rst       (rst),
        .push      (complete && !drop),
        .push_data ({be_mask(bytes_after), acc_wr}),
        .pop       (pop),
        .full      (q_full),
        .empty     (q_empty),
        .head      (q_head)
    );

    assign word_valid = !q_empty;
    assign be_out     = q_head[ENTRY_W-1:WORD_W];
    assign word_out   = q_head[WORD_W-1:0];
    assign fill       = lane;

    // Accumulator FSM: collect bytes, clear on every completion (kept or dropped)
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_EMPTY;
            lane  <= '0;
            acc   <= '0;
        end else if (complete) begin
            state <= ST_EMPTY;
            lane  <= '0;
            acc   <= '0;
        end else if (din_valid) begin
            state <= ST_PARTIAL;
            lane  <= lane + 1'b1;
            acc   <= acc_wr;
        end
    end

    // Loss flags: one-cycle pulse per dropped word, sticky until reset
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow        <= 1'b0;
            overflow_sticky <= 1'b0;
        end else begin
            overflow        <= drop;
            overflow_sticky <= overflow_sticky | drop;
        end
    end

endmodule

// File: tb/tb_arb_word_packer.sv
// tb/tb_arb_word_packer.sv - self-checking bench for arb_word_packer
module tb_arb_word_packer;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  din;
    logic        din_valid;
    logic        flush;
    logic [31:0] word_out;
    logic [3:0]  be_out;
    logic        word_valid;
    logic        word_ready;
    logic        overflow;
    logic        overflow_sticky;
    logic [1:0]  fill;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0]  m_bytes[$];
    logic [35:0] m_words[$];
    logic        m_ovf;
    logic        m_sticky;

    arb_word_packer #(.OUT_DEPTH(DEPTH)) dut (
        .clk             (clk),
        .rst             (rst),
        .din             (din),
        .din_valid       (din_valid),
        .flush           (flush),
        .word_out        (word_out),
        .be_out          (be_out),
        .word_valid      (word_valid),
        .word_ready      (word_ready),
        .overflow        (overflow),
        .overflow_sticky (overflow_sticky),
        .fill            (fill)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [35:0] obs, input logic [35:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: bytes held as a list, output queue as a list of {be, word}
    task automatic model_step(input logic dv, input logic [7:0] d, input logic fl,
                              input logic rdy, input logic r);
        logic [31:0] w;
        logic [3:0]  be;
        int          n;
        if (r) begin
            m_bytes.delete();
            m_words.delete();
            m_ovf    = 1'b0;
            m_sticky = 1'b0;
            return;
        end
        m_ovf = 1'b0;
        if (rdy && m_words.size() > 0) void'(m_words.pop_front());
        if (dv) m_bytes.push_back(d);
        n = m_bytes.size();
        if (n == 4 || (fl && n > 0)) begin
            w = 32'h0;
            for (int i = 0; i < n; i++) w = w | (32'(m_bytes[i]) << (8 * i));
            be = 4'((1 << n) - 1);
            m_bytes.delete();
            if (m_words.size() < DEPTH) m_words.push_back({be, w});
            else begin
                m_ovf    = 1'b1;
                m_sticky = 1'b1;
            end
        end
    endtask

    task automatic check_all();
        chk("word_valid", word_valid, m_words.size() > 0);
        if (m_words.size() > 0) begin
            chk("word_out", word_out, m_words[0][31:0]);
            chk("be_out", be_out, m_words[0][35:32]);
        end
        chk("overflow", overflow, m_ovf);
        chk("overflow_sticky", overflow_sticky, m_sticky);
        chk("fill", fill, m_bytes.size());
    endtask

    task automatic step(input logic dv, input logic [7:0] d, input logic fl,
                        input logic rdy, input logic r);
        din_valid  = dv;
        din        = d;
        flush      = fl;
        word_ready = rdy;
        rst        = r;
        @(posedge clk);
        model_step(dv, d, fl, rdy, r);
        #1;
        check_all();
    endtask

    initial begin
        m_ovf    = 1'b0;
        m_sticky = 1'b0;

        // Reset state
        step(0, 8'h00, 0, 0, 1);
        chk("rst_word_out", word_out, 32'h0);
        chk("rst_be_out", be_out, 4'h0);
        chk("rst_valid", word_valid, 1'b0);
        chk("rst_fill", fill, 2'd0);

        // Four bytes into one full word, valid for exactly one cycle
        step(1, 8'h11, 0, 1, 0);
        step(1, 8'h22, 0, 1, 0);
        step(1, 8'h33, 0, 1, 0);
        chk("tp1_pre_valid", word_valid, 1'b0);
        step(1, 8'h44, 0, 1, 0);
        chk("tp1_word", word_out, 32'h44332211);
        chk("tp1_be", be_out, 4'hF);
        chk("tp1_valid", word_valid, 1'b1);
        step(0, 8'h00, 0, 1, 0);
        chk("tp1_valid_drop", word_valid, 1'b0);

        // Two bytes then a lone flush; then an idle flush emits nothing
        step(1, 8'hAA, 0, 1, 0);
        step(1, 8'hBB, 0, 1, 0);
        step(0, 8'h00, 1, 1, 0);
        chk("tp2_word", word_out, 32'h0000BBAA);
        chk("tp2_be", be_out, 4'h3);
        step(0, 8'h00, 1, 1, 0);
        chk("tp2_idle_flush", word_valid, 1'b0);
        step(0, 8'h00, 0, 1, 0);
        chk("tp2_idle_after", word_valid, 1'b0);

        // Byte and flush together at lane 2
        step(1, 8'h01, 0, 1, 0);
        step(1, 8'h02, 0, 1, 0);
        step(1, 8'hCC, 1, 1, 0);
        chk("tp3_word", word_out, 32'h00CC0201);
        chk("tp3_be", be_out, 4'h7);
        chk("tp3_fill", fill, 2'd0);
        step(0, 8'h00, 0, 1, 0);

        // Backpressure: third word dropped, queue drains in order
        for (int i = 0; i < 12; i++) step(1, 8'(i), 0, 0, 0);
        chk("tp4_ovf", overflow, 1'b1);
        chk("tp4_sticky", overflow_sticky, 1'b1);
        chk("tp4_head0", word_out, 32'h03020100);
        step(0, 8'h00, 0, 0, 0);
        chk("tp4_ovf_pulse", overflow, 1'b0);
        step(0, 8'h00, 0, 1, 0);
        chk("tp4_head1", word_out, 32'h07060504);
        step(0, 8'h00, 0, 1, 0);
        chk("tp4_drained", word_valid, 1'b0);

        // Full queue with a pop on the completing cycle: no drop
        for (int i = 0; i < 11; i++) step(1, 8'(8'h10 + i), 0, 0, 0);
        step(1, 8'h1B, 0, 1, 0);
        chk("tp5_no_ovf", overflow, 1'b0);
        chk("tp5_head", word_out, 32'h17161514);
        step(0, 8'h00, 0, 1, 0);
        chk("tp5_third", word_out, 32'h1B1A1918);
        step(0, 8'h00, 0, 1, 0);

        // Reset mid-operation with a queued word and two bytes held
        for (int i = 0; i < 6; i++) step(1, 8'(8'h20 + i), 0, 0, 0);
        chk("tp6_pre_fill", fill, 2'd2);
        step(1, 8'hEE, 1, 1, 1);
        chk("tp6_valid", word_valid, 1'b0);
        chk("tp6_fill", fill, 2'd0);
        chk("tp6_sticky", overflow_sticky, 1'b0);
        for (int i = 0; i < 4; i++) step(1, 8'(8'h30 + i), 0, 0, 0);
        chk("tp6_word", word_out, 32'h33323130);
        chk("tp6_be", be_out, 4'hF);

        // Randomized traffic against the reference
        for (int c = 0; c < 3000; c++) begin
            step(($urandom_range(0, 9) < 7), 8'($urandom), ($urandom_range(0, 9) == 0),
                 ($urandom_range(0, 9) < 6), ($urandom_range(0, 299) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/arb_word_packer.md
# arb_word_packer

- Downstream stage of the 4-channel round-robin FIFO arbiter.
- Collects the arbiter's byte stream (8-bit data plus a one-cycle valid) and packs consecutive bytes little-endian into 32-bit words with byte enables.
- Buffers completed words in a small output queue behind a valid/ready handshake.
- The arbiter cannot be stalled, so loss under backpressure is detected and flagged rather than prevented.

## Interface
- `OUT_DEPTH`, default 2: output word queue depth; power of two, ≥2.
- `clk` input, 1 bit: single clock; all logic on its rising edge.
- `rst` input, 1 bit: synchronous, active-high reset.
- `din` input, 8 bits: byte from the arbiter.
- `din_valid` input, 1 bit: `din` is meaningful this cycle; no ready/backpressure on this side.
- `flush` input, 1 bit: close the current partial word and emit it.
- `word_out` output, 32 bits: head word of the queue; byte lane k is `word_out[8k+7:8k]`.
- `be_out` output, 4 bits: lane-valid mask for `word_out`; always contiguous from lane 0.
- `word_valid` output, 1 bit: queue non-empty.
- `word_ready` input, 1 bit: consumer accepts the head word when `word_valid & word_ready`.
- `overflow` output, 1 bit: one-cycle pulse when a completed word is dropped.
- `overflow_sticky` output, 1 bit: set by any drop; cleared only by `rst`.
- `fill` output, 2 bits: bytes currently held in the accumulator (0–3).

## Operation
- The accumulator holds `lane` (0–3) and a 32-bit word register.
- On `din_valid`, `din` is written to lane `lane`, then `lane` increments.
- A word completes when either:
  - `din_valid` arrives with `lane==3`, giving `be=4'b1111`; or
  - `flush` is high with at least one byte held (counting a byte arriving the same cycle), giving `be` = lanes written.
- On completion:
  - `{be, word}` is pushed into the output queue.
  - The accumulator clears: `lane=0`, word register zeroed.
- Unwritten lanes of an emitted word are `8'h00`.
- `flush` with `lane==0` and no `din_valid` is a no-op. Nothing is pushed; an empty word is never emitted.
- `flush` together with `din_valid`: the byte is included first, then the word is closed. With `lane==3` this is an ordinary full word, one push.
- Queue full on push:
  - If `word_valid & word_ready` in the same cycle, the pop frees a slot and the push succeeds.
  - Otherwise the new word is dropped and `overflow` pulses that cycle. The accumulator still clears.
- Queue order is FIFO. Read and write pointers wrap modulo `OUT_DEPTH`. Occupancy is tracked with a `log2(OUT_DEPTH)+1`-bit counter, with no full/empty ambiguity.
- Reset values:
  - Outputs: `word_out=0`, `be_out=0`, `word_valid=0`, `overflow=0`, `overflow_sticky=0`, `fill=0`.
  - Internal: queue empty, pointers at 0.
- Reset mid-operation discards partial bytes and queued words without emitting them. Inputs during the reset cycle are ignored.
- The accumulator behaves as a control FSM:
  - EMPTY (`lane==0`) → PARTIAL on `din_valid`.
  - PARTIAL (`lane` 1–3) → EMPTY on completion; otherwise it stays and increments.

## Timing
- All state updates at the rising edge of `clk`. `rst` is sampled at the edge.
- The byte accepted at edge N that completes a word is visible at the queue head after edge N, so `word_valid` rises one cycle after the completing byte, when the queue was empty.
- `word_out` and `be_out` are driven directly from queue storage at the read pointer. They are stable while `word_valid & !word_ready`.
- A handshake at edge M advances the head; the next word, if any, is presented after edge M.
- `overflow` is asserted for exactly the cycle following the dropping edge. `overflow_sticky` rises at the same time.
- `fill` reflects the registered `lane`.
- Throughput: one word per 4 input cycles sustained. The queue is never the bottleneck while `word_ready` is high.

## Structure
- Shared package `arb_pack_pkg`:
  - `BYTE_W=8`, `WORD_BYTES=4`, `LANE_W=2`, `WORD_W=32`.
  - Accumulator state encoding `ST_EMPTY`, `ST_PARTIAL`.
- Sub-module `word_queue`: parameterised synchronous FIFO, width 36 (`be` + word), depth `OUT_DEPTH`.
  - Ports: push, pop, full, empty, head data.
  - Push while full is rejected internally; push-when-full-with-pop is handled by the parent via `full & !pop`.
- Top level: accumulator, lane counter, completion/flush logic, overflow flags.

## Test plan
- Input bytes `11,22,33,44` on four consecutive cycles with `word_ready=1` → one word, `word_out=32'h44332211`, `be_out=4'hF`, `word_valid` high for exactly 1 cycle, one cycle after byte `44`.
- Bytes `AA,BB`, then `flush` alone → `word_out=32'h0000BBAA`, `be_out=4'h3`. A further idle `flush` with `fill==0` → no word.
- `din_valid=1`, `din=CC` together with `flush` at `lane==2` (bytes `01,02` held) → `word_out=32'h00CC0201`, `be_out=4'h7`, `fill` returns to 0.
- `word_ready=0`, `OUT_DEPTH=2`, twelve bytes `00..0B` →
  - Queue holds `03020100` and `07060504`.
  - Third word dropped; `overflow` pulses once; `overflow_sticky=1`.
  - Releasing `word_ready` drains exactly the 2 queued words in order.
- Queue full with `word_ready=1` on the completing cycle → no drop, `overflow=0`, three words delivered in order.
- Assert `rst` for 1 cycle with `fill=2` and one queued word → after the edge `word_valid=0`, `fill=0`, `overflow_sticky=0`. The next four bytes form a clean word with `be_out=4'hF`.
